// File: rtl/env_det_scheduler.sv
// Shared rectify-and-envelope datapath, time-multiplexed over NUM_CH AM channels.
// A round-robin arbiter feeds one sample per cycle; per-channel envelope state lives in a register file.
module env_det_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 12,
  parameter int ATTACK_SHIFT = 0,
  parameter int DECAY_SHIFT  = 11,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH*DATA_W-1:0] i_in_data,
  input  logic [NUM_CH-1:0]        i_data_valid,
  output logic [NUM_CH-1:0]        o_data_ready,
  input  logic [NUM_CH-1:0]        i_ch_clear,
  output logic [DATA_W-1:0]        o_data,
  output logic [CH_W-1:0]          o_data_ch,
  output logic                     o_data_valid,
  input  logic                     i_data_ready
);

  localparam logic [DATA_W-1:0]        ENV_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0]   ONE     = {{DATA_W{1'b0}}, 1'b1};

  // |s|; the single unrepresentable magnitude (most negative input) clips to ENV_MAX
  function automatic logic [DATA_W-1:0] rectify(input logic signed [DATA_W-1:0] s);
    logic [DATA_W-1:0] mag;
    mag = s[DATA_W-1] ? -s : s;
    return mag[DATA_W-1] ? ENV_MAX : mag;
  endfunction

  // Attack toward rect with at least one LSB of movement; decay by env>>DECAY_SHIFT (min 1), never below rect
  function automatic logic [DATA_W-1:0] env_next(input logic [DATA_W-1:0] rect,
                                                 input logic [DATA_W-1:0] env);
    logic signed [DATA_W:0] r, e, diff, step, cand, res;
    r    = signed'({1'b0, rect});
    e    = signed'({1'b0, env});
    diff = r - e;
    if (diff == '0) begin
      res = e;
    end else if (!diff[DATA_W]) begin
      step = diff >>> ATTACK_SHIFT;
      if (step == '0) step = ONE;
      res = e + step;
    end else begin
      step = e >>> DECAY_SHIFT;
      if (step == '0) step = ONE;
      cand = e - step;
      res  = (cand < r) ? r : cand;
    end
    return res[DATA_W-1:0];
  endfunction

  logic                     adv;
  logic                     gnt_found;
  logic [CH_W-1:0]          gnt_ch;
  logic [CH_W-1:0]          scan_ch;
  logic [CH_W-1:0]          rr_ptr;
  logic [CH_W-1:0]          rr_next;
  logic signed [DATA_W-1:0] gnt_samp;
  logic                     vld_p1;
  logic [CH_W-1:0]          ch_p1;
  logic [DATA_W-1:0]        rect_p1;
  logic [DATA_W-1:0]        env_new;
  logic [DATA_W-1:0]        env_st [NUM_CH];

  assign adv = !o_data_valid || i_data_ready;

  // Descending scan so the last hit is the requester closest to rr_ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    scan_ch   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      scan_ch = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (i_data_valid[scan_ch]) begin
        gnt_found = 1'b1;
        gnt_ch    = scan_ch;
      end
    end
  end

  always_comb begin
    o_data_ready = '0;
    if (adv && gnt_found) o_data_ready[gnt_ch] = 1'b1;
  end

  assign gnt_samp = i_in_data[gnt_ch*DATA_W +: DATA_W];
  assign rr_next  = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
  assign env_new  = env_next(rect_p1, env_st[ch_p1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr       <= '0;
      vld_p1       <= 1'b0;
      ch_p1        <= '0;
      rect_p1      <= '0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_data_ch    <= '0;
      for (int k = 0; k < NUM_CH; k++) env_st[k] <= '0;
    end else begin
      if (adv) begin
        // S1: granted channel and its rectified sample
        vld_p1 <= gnt_found;
        if (gnt_found) begin
          ch_p1   <= gnt_ch;
          rect_p1 <= rectify(gnt_samp);
          rr_ptr  <= rr_next;
        end
        // S2: envelope update, writeback and output register
        o_data_valid <= vld_p1;
        if (vld_p1) begin
          o_data         <= env_new;
          o_data_ch      <= ch_p1;
          env_st[ch_p1]  <= env_new;
        end
      end
      // Later assignment takes priority over a same-edge writeback
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_ch_clear[k]) env_st[k] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_env_det_scheduler.sv
// Directed bench for env_det_scheduler: transaction-level envelope model plus hand-computed output list.
module tb_env_det_scheduler;
  localparam int N = 4;
  localparam int W = 12;
  localparam int EMAX = (1 << (W - 1)) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   dvalid;
  logic [N-1:0]   dready;
  logic [N-1:0]   ch_clear;
  logic [W-1:0]   odata;
  logic [1:0]     och;
  logic           ovalid;
  logic           oready;

  always #5 clk = ~clk;

  env_det_scheduler #(.NUM_CH(N), .DATA_W(W), .ATTACK_SHIFT(0), .DECAY_SHIFT(11)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(in_data), .i_data_valid(dvalid),
    .o_data_ready(dready), .i_ch_clear(ch_clear), .o_data(odata), .o_data_ch(och),
    .o_data_valid(ovalid), .i_data_ready(oready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: envelope per channel, pointer, one in-flight sample and one output slot
  int m_env [N] = '{default: 0};
  int m_ptr = 0;
  bit m_s1v = 0;
  int m_s1ch = 0;
  int m_s1d = 0;
  bit m_ov = 0;
  int m_och = 0;
  int m_od = 0;
  int mg;
  int eg;

  typedef struct { int ch; int val; } lit_t;
  lit_t lit_q[$];
  lit_t lit;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rect_of(input int s);
    int r;
    r = (s < 0) ? -s : s;
    return (r > EMAX) ? EMAX : r;
  endfunction

  function automatic int env_model(input int rect, input int env);
    int d;
    if (rect > env) begin
      d = rect - env;
      return env + ((d == 0) ? 1 : d);
    end else if (rect < env) begin
      d = env / 2048;
      if (d < 1) d = 1;
      return (env - d > rect) ? env - d : rect;
    end
    return env;
  endfunction

  function automatic int samp(input int k);
    logic signed [W-1:0] t;
    t = in_data[k*W +: W];
    return int'(t);
  endfunction

  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      if (dvalid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic set_ch(input int k, input int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    in_data[k*W +: W] = t;
  endtask

  task automatic push_lit(input int c, input int v);
    lit_t l;
    l.ch = c;
    l.val = v;
    lit_q.push_back(l);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model update on each active edge (and immediately on reset assertion)
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_env[k] = 0;
      m_ptr = 0; m_s1v = 0; m_ov = 0; m_od = 0; m_och = 0;
    end else begin
      if (!m_ov || oready) begin
        if (m_s1v) begin
          m_od = env_model(rect_of(m_s1d), m_env[m_s1ch]);
          m_env[m_s1ch] = m_od;
          m_och = m_s1ch;
        end
        m_ov = m_s1v;
        mg = model_grant();
        m_s1v = (mg >= 0);
        if (mg >= 0) begin
          m_s1ch = mg;
          m_s1d = samp(mg);
          m_ptr = (mg + 1) % N;
        end
      end
      for (int k = 0; k < N; k++) if (ch_clear[k]) m_env[k] = 0;
    end
  end

  // Per-cycle compare against model and the hand-computed output list
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("reset_valid", int'(ovalid), 0);
      check("reset_data", int'(odata), 0);
      check("reset_ch", int'(och), 0);
    end else begin
      eg = (!m_ov || oready) ? model_grant() : -1;
      check("ready", int'(dready), (eg >= 0) ? (1 << eg) : 0);
      check("valid", int'(ovalid), int'(m_ov));
      if (m_ov) begin
        check("data", int'(odata), m_od);
        check("ch", int'(och), m_och);
      end
      if (ovalid && oready) begin
        if (lit_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL lit_extra: got unexpected output ch %0d data %0d (t=%0t)", och, odata, $time);
        end else begin
          lit = lit_q.pop_front();
          check("lit_ch", int'(och), lit.ch);
          check("lit_data", int'(odata), lit.val);
        end
      end
    end
  end

  initial begin
    in_data = '0; dvalid = '0; ch_clear = '0; oready = 1'b1; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);

    // Single sample, latency two cycles
    set_ch(0, 1000); dvalid = 4'b0001; push_lit(0, 1000);
    step(1); dvalid = '0;
    check("lat_t1_valid", int'(ovalid), 0);
    step(1);
    check("lat_t2_valid", int'(ovalid), 1);
    check("lat_t2_data", int'(odata), 1000);
    check("lat_t2_ch", int'(och), 0);
    step(2);

    // Attack then minimum-step decay
    set_ch(1, 1000); dvalid = 4'b0010;
    push_lit(1, 1000); push_lit(1, 999); push_lit(1, 998); push_lit(1, 997);
    step(1); set_ch(1, 0);
    step(3); dvalid = '0;
    step(3);

    // Saturating rectify, negative input magnitude
    set_ch(2, -2048); dvalid = 4'b0100; push_lit(2, 2047);
    step(1); dvalid = '0;
    step(2);
    set_ch(3, -5); dvalid = 4'b1000; push_lit(3, 5);
    step(1); dvalid = '0;
    step(3);

    // All channels requesting, with a 5-cycle downstream stall in the middle
    for (int k = 0; k < N; k++) set_ch(k, 1500);
    dvalid = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      push_lit(0, 1500); push_lit(1, 1500); push_lit(2, 2046 - r); push_lit(3, 1500);
    end
    for (int c = 0; c < 13; c++) begin
      oready = !(c >= 4 && c <= 8);
      #1;
      if (c == 6) begin
        check("stall_ready", int'(dready), 0);
        check("stall_valid", int'(ovalid), 1);
      end
      @(posedge clk);
      #1;
    end
    dvalid = '0; oready = 1'b1;
    step(4);

    // Clear coinciding with channel 3 writeback
    set_ch(3, 1500); dvalid = 4'b1000; push_lit(3, 1500);
    step(1); dvalid = '0; ch_clear = 4'b1000;
    step(1); ch_clear = '0;
    check("clr_out", int'(odata), 1500);
    set_ch(3, 100); dvalid = 4'b1000; push_lit(3, 100);
    step(1); dvalid = '0;
    step(3);

    // Reset in the middle of traffic
    for (int k = 0; k < N; k++) set_ch(k, 300);
    dvalid = 4'b1111; push_lit(0, 1499);
    step(3);
    rst_n = 1'b0; dvalid = '0;
    #1 check("rst_drop_valid", int'(ovalid), 0);
    check("rst_lit_drained", lit_q.size(), 0);
    lit_q.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
    set_ch(0, 300); set_ch(1, -100); dvalid = 4'b0011;
    push_lit(0, 300); push_lit(1, 100);
    step(2); dvalid = '0;
    step(4);

    check("lit_drain", lit_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
